// File: rtl/regfile_fwd_dbg.sv
// General-purpose register file with EX/MEM/WB operand forwarding, per-port load-use stall
// detection and an arbitrated debug access port. Define REGFILE_FWD_EN to enable EX/MEM forwarding.
module regfile_fwd_dbg #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_we_i,
    input  logic [ADDR_W-1:0]          wb_waddr_i,
    input  logic [DATA_W-1:0]          wb_wdata_i,
    input  logic                       ex_we_i,
    input  logic [ADDR_W-1:0]          ex_waddr_i,
    input  logic                       ex_valid_i,
    input  logic [DATA_W-1:0]          ex_wdata_i,
    input  logic                       mem_we_i,
    input  logic [ADDR_W-1:0]          mem_waddr_i,
    input  logic [DATA_W-1:0]          mem_wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_stall_o,
    input  logic                       dbg_req_i,
    input  logic                       dbg_we_i,
    input  logic [ADDR_W-1:0]          dbg_addr_i,
    input  logic [DATA_W-1:0]          dbg_wdata_i,
    output logic                       dbg_ack_o,
    output logic [DATA_W-1:0]          dbg_rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dbg_state_e;

    dbg_state_e         state_q;
    logic               dbg_ack_q;
    logic [DATA_W-1:0]  dbg_rdata_q;
    logic [DATA_W-1:0]  regs_q [DEPTH];

    logic               wb_wr_en;
    logic               dbg_wr_fire;
    logic               dbg_wr_en;
    logic [DATA_W-1:0]  dbg_rd_val;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Debug handshake: dbg_req_i rises with dbg_we_i/dbg_addr_i/dbg_wdata_i stable and is held
    // until dbg_ack_o pulses for one cycle; the requester must drop dbg_req_i in that ack cycle.
    assign wb_wr_en    = wb_we_i && !is_zero(wb_waddr_i);
    assign dbg_wr_fire = dbg_we_i && !wb_we_i &&
                         (((state_q == ST_IDLE) && dbg_req_i) || (state_q == ST_WAIT));
    assign dbg_wr_en   = dbg_wr_fire && !is_zero(dbg_addr_i);
    assign dbg_rd_val  = (wb_wr_en && (wb_waddr_i == dbg_addr_i)) ? wb_wdata_i
                                                                   : regs_q[dbg_addr_i];

    // Writeback owns the write port; the debug FSM only fires in cycles where wb is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wb_wr_en) begin
            regs_q[wb_waddr_i] <= wb_wdata_i;
        end else if (dbg_wr_en) begin
            regs_q[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dbg_req_i) begin
                        if (!dbg_we_i) begin
                            dbg_rdata_q <= dbg_rd_val;
                            state_q     <= ST_RESP;
                        end else if (wb_we_i) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb_we_i) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    dbg_ack_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_ack_o   = dbg_ack_q;
    assign dbg_rdata_o = dbg_rdata_q;

`ifndef REGFILE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_valid_i, ex_wdata_i, mem_wdata_i};
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              stall;
        logic              ex_hit;
        logic              mem_hit;
        logic              wb_hit;

        assign addr    = rd_addr_i[p*ADDR_W +: ADDR_W];
        assign ex_hit  = ex_we_i  && (ex_waddr_i  == addr) && !is_zero(addr);
        assign mem_hit = mem_we_i && (mem_waddr_i == addr) && !is_zero(addr);
        assign wb_hit  = wb_we_i  && (wb_waddr_i  == addr) && !is_zero(addr);

        always_comb begin
            data  = '0;
            stall = 1'b0;
            if (is_zero(addr)) begin
                data = '0;
`ifdef REGFILE_FWD_EN
            end else if (ex_hit) begin
                // A load in EX has no result yet: hold ID until it reaches MEM.
                stall = !ex_valid_i;
                data  = ex_valid_i ? ex_wdata_i : '0;
            end else if (mem_hit) begin
                data = mem_wdata_i;
`else
            end else if (ex_hit || mem_hit) begin
                stall = 1'b1;
`endif
            end else if (wb_hit) begin
                data = wb_wdata_i;
            end else begin
                data = regs_q[addr];
            end
        end

        assign rd_data_o[p*DATA_W +: DATA_W] = data;
        assign rd_stall_o[p]                 = stall;
    end

endmodule

// File: tb/tb_regfile_fwd_dbg.sv
// Self-checking bench for regfile_fwd_dbg: directed scenarios plus randomized read-port and debug
// traffic checked against a register-array model. Honours REGFILE_FWD_EN like the design.
module tb_regfile_fwd_dbg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 32;
`ifdef REGFILE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wb_we, ex_we, ex_valid, mem_we;
    logic [ADDR_W-1:0]        wb_waddr, ex_waddr, mem_waddr;
    logic [DATA_W-1:0]        wb_wdata, ex_wdata, mem_wdata;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_stall;
    logic                     dbg_req, dbg_we, dbg_ack;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_wdata, dbg_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] model_regs [DEPTH];
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_fwd_dbg #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_valid_i(ex_valid), .ex_wdata_i(ex_wdata),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_stall_o(rd_stall),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) model_regs[k] = '0;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        ex_we = 0; ex_waddr = '0; ex_valid = 0; ex_wdata = '0;
        mem_we = 0; mem_waddr = '0; mem_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        rd_addr = '0;
    endtask

    // One clock: the model retires the writeback presented during the cycle that just ended.
    task automatic step();
        @(posedge clk);
        if (rst) clear_model();
        else if (wb_we && !(ZERO_REG != 0 && wb_waddr == 0)) model_regs[wb_waddr] = wb_wdata;
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Reference read: priority zero-reg > EX > MEM > WB > array.
    function automatic void exp_read(input logic [ADDR_W-1:0] a,
                                     output logic [DATA_W-1:0] d, output logic s);
        d = '0;
        s = 1'b0;
        if (ZERO_REG != 0 && a == 0) return;
        if (ex_we && ex_waddr == a) begin
            if (FWD_EN && ex_valid) d = ex_wdata;
            else s = 1'b1;
        end else if (mem_we && mem_waddr == a) begin
            if (FWD_EN) d = mem_wdata;
            else s = 1'b1;
        end else if (wb_we && wb_waddr == a) begin
            d = wb_wdata;
        end else begin
            d = model_regs[a];
        end
    endfunction

    // Runs one debug transaction; wb is busy for busy_n cycles starting in the request cycle.
    task automatic do_dbg(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int busy_n,
                          input logic [ADDR_W-1:0] busy_addr, input logic [DATA_W-1:0] busy_data0,
                          output int ack_cyc, output int ack_cnt,
                          output logic [DATA_W-1:0] rdata_ack, output logic [DATA_W-1:0] rdata_after);
        ack_cyc = -1;
        ack_cnt = 0;
        rdata_ack = '0;
        dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        wb_we = (busy_n > 0); wb_waddr = busy_addr; wb_wdata = busy_data0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (dbg_ack === 1'b1) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = c;
                    rdata_ack = dbg_rdata;
                    dbg_req = 0;
                end
            end
            wb_we = (c < busy_n);
            wb_waddr = busy_addr + 5'(c);
            wb_wdata = $urandom;
            if (ack_cyc >= 0 && c >= ack_cyc + 3) break;
        end
        dbg_req = 0;
        wb_we = 0;
        rdata_after = dbg_rdata;
        if (ack_cyc >= 0 && we && !(ZERO_REG != 0 && addr == 0)) model_regs[addr] = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [DATA_W-1:0] ed;
        logic es;
        idle_inputs();
        rst = 1;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dbg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", dbg_ack); end
        n_checks++;
        if (dbg_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
        @(posedge clk); #1;
        rst = 0;
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(5'(a), 5'(DEPTH - 1 - a));
            @(negedge clk);
            for (int p = 0; p < NUM_RD; p++) begin
                exp_read(rd_addr[p*ADDR_W +: ADDR_W], ed, es);
                n_checks++;
                if (rd_stall[p] !== es || rd_data[p*DATA_W +: DATA_W] !== ed) begin
                    n_fail++;
                    $display("FAIL reset_regs port%0d addr %0d got %h/%b exp %h/%b", p,
                             rd_addr[p*ADDR_W +: ADDR_W], rd_data[p*DATA_W +: DATA_W], rd_stall[p], ed, es);
                end
            end
            step();
        end
    endtask

    task automatic test_wb_bypass();
        idle_inputs();
        wb_we = 1; wb_waddr = 3; wb_wdata = 32'h11;
        set_rd(5'd3, 5'd5);
        @(negedge clk);
        n_checks++;
        if (rd_data[DATA_W-1:0] !== 32'h11 || rd_stall[0] !== 1'b0) begin
            n_fail++; $display("FAIL wb_bypass got %h/%b exp 00000011/0", rd_data[DATA_W-1:0], rd_stall[0]);
        end
        step();
        wb_we = 0;
        @(negedge clk);
        n_checks++;
        if (rd_data[DATA_W-1:0] !== 32'h11) begin
            n_fail++; $display("FAIL wb_array got %h exp 00000011", rd_data[DATA_W-1:0]);
        end
        step();
    endtask

    task automatic test_fwd_priority();
        logic [1:0] exp_stall_valid;
        exp_stall_valid = FWD_EN ? 2'b00 : 2'b11;
        idle_inputs();
        set_rd(5'd7, 5'd7);
        ex_we = 1; ex_waddr = 7; ex_valid = 1; ex_wdata = 32'hA;
        mem_we = 1; mem_waddr = 7; mem_wdata = 32'hB;
        wb_we = 1; wb_waddr = 7; wb_wdata = 32'hC;
        @(negedge clk);
        n_checks++;
        if (rd_stall !== exp_stall_valid) begin
            n_fail++; $display("FAIL fwd_ex_valid_stall got %b exp %b", rd_stall, exp_stall_valid);
        end
        for (int p = 0; p < NUM_RD; p++) begin
            n_checks++;
            if (rd_stall[p] === 1'b0 && rd_data[p*DATA_W +: DATA_W] !== 32'hA) begin
                n_fail++; $display("FAIL fwd_ex_data port%0d got %h exp 0000000a", p, rd_data[p*DATA_W +: DATA_W]);
            end
        end
        ex_valid = 0;
        @(negedge clk);
        n_checks++;
        if (rd_stall !== 2'b11) begin
            n_fail++; $display("FAIL fwd_ex_load_stall got %b exp 11", rd_stall);
        end
        ex_we = 0;
        @(negedge clk);
        n_checks++;
        if (rd_stall !== exp_stall_valid) begin
            n_fail++; $display("FAIL fwd_mem_stall got %b exp %b", rd_stall, exp_stall_valid);
        end
        for (int p = 0; p < NUM_RD; p++) begin
            n_checks++;
            if (rd_stall[p] === 1'b0 && rd_data[p*DATA_W +: DATA_W] !== 32'hB) begin
                n_fail++; $display("FAIL fwd_mem_data port%0d got %h exp 0000000b", p, rd_data[p*DATA_W +: DATA_W]);
            end
        end
        mem_we = 0;
        @(negedge clk);
        n_checks++;
        if (rd_stall !== 2'b00 || rd_data !== {32'hC, 32'hC}) begin
            n_fail++; $display("FAIL fwd_wb got %h/%b exp 0000000c0000000c/00", rd_data, rd_stall);
        end
        step();
        wb_we = 0;
    endtask

    task automatic test_zero_reg();
        int ack_cyc, ack_cnt;
        logic [DATA_W-1:0] ra, rb;
        idle_inputs();
        set_rd(5'd0, 5'd0);
        ex_we = 1; ex_waddr = 0; ex_valid = 0; ex_wdata = 32'h5;
        mem_we = 1; mem_waddr = 0; mem_wdata = 32'h6;
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'h7;
        @(negedge clk);
        n_checks++;
        if (rd_stall !== 2'b00 || rd_data !== '0) begin
            n_fail++; $display("FAIL zero_read got %h/%b exp 0/00", rd_data, rd_stall);
        end
        step();
        idle_inputs();
        do_dbg(1'b1, 5'd0, 32'hFF, 0, 5'd0, '0, ack_cyc, ack_cnt, ra, rb);
        n_checks++;
        if (ack_cyc != 2 || ack_cnt != 1) begin
            n_fail++; $display("FAIL zero_dbg_ack got cyc %0d cnt %0d exp cyc 2 cnt 1", ack_cyc, ack_cnt);
        end
        set_rd(5'd0, 5'd0);
        @(negedge clk);
        n_checks++;
        if (rd_data !== '0 || rd_stall !== 2'b00) begin
            n_fail++; $display("FAIL zero_after_dbg got %h/%b exp 0/00", rd_data, rd_stall);
        end
        step();
    endtask

    task automatic test_dbg_contended();
        int ack_cyc, ack_cnt;
        logic [DATA_W-1:0] ra, rb;
        idle_inputs();
        do_dbg(1'b1, 5'd9, 32'h1234, 3, 5'd20, 32'h2020, ack_cyc, ack_cnt, ra, rb);
        n_checks++;
        if (ack_cyc != 5 || ack_cnt != 1) begin
            n_fail++; $display("FAIL contended_ack got cyc %0d cnt %0d exp cyc 5 cnt 1", ack_cyc, ack_cnt);
        end
        set_rd(5'd9, 5'd20);
        @(negedge clk);
        n_checks++;
        if (rd_data[DATA_W-1:0] !== 32'h1234) begin
            n_fail++; $display("FAIL contended_x9 got %h exp 00001234", rd_data[DATA_W-1:0]);
        end
        n_checks++;
        if (rd_data[2*DATA_W-1:DATA_W] !== 32'h2020) begin
            n_fail++; $display("FAIL contended_x20 got %h exp 00002020", rd_data[2*DATA_W-1:DATA_W]);
        end
        set_rd(5'd21, 5'd22);
        #1;
        n_checks++;
        if (rd_data !== {model_regs[22], model_regs[21]}) begin
            n_fail++; $display("FAIL contended_x21_x22 got %h exp %h", rd_data, {model_regs[22], model_regs[21]});
        end
        step();
    endtask

    task automatic test_dbg_read_bypass();
        int ack_cyc, ack_cnt;
        logic [DATA_W-1:0] ra, rb;
        idle_inputs();
        wb_we = 1; wb_waddr = 4; wb_wdata = 32'h55;
        step();
        wb_we = 0;
        do_dbg(1'b0, 5'd4, '0, 1, 5'd4, 32'h66, ack_cyc, ack_cnt, ra, rb);
        n_checks++;
        if (ack_cyc != 2 || ack_cnt != 1) begin
            n_fail++; $display("FAIL rd_bypass_ack got cyc %0d cnt %0d exp cyc 2 cnt 1", ack_cyc, ack_cnt);
        end
        n_checks++;
        if (ra !== 32'h66) begin
            n_fail++; $display("FAIL rd_bypass_data got %h exp 00000066", ra);
        end
        n_checks++;
        if (rb !== 32'h66) begin
            n_fail++; $display("FAIL rd_bypass_hold got %h exp 00000066", rb);
        end
    endtask

    task automatic test_reset_mid_wait();
        int ack_cyc, ack_cnt, acks;
        logic [DATA_W-1:0] ra, rb;
        idle_inputs();
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'h77;
        step();
        dbg_req = 1; dbg_we = 1; dbg_addr = 5; dbg_wdata = 32'hDEAD;
        wb_we = 1; wb_waddr = 6; wb_wdata = 32'h99;
        acks = 0;
        repeat (2) begin
            step();
            if (dbg_ack !== 1'b0) acks++;
        end
        rst = 1; dbg_req = 0; wb_we = 0;
        clear_model();
        #1;
        n_checks++;
        if (dbg_ack !== 1'b0 || dbg_rdata !== '0) begin
            n_fail++; $display("FAIL midwait_async got ack %b rdata %h exp 0/0", dbg_ack, dbg_rdata);
        end
        step();
        rst = 0;
        repeat (4) begin
            step();
            if (dbg_ack !== 1'b0) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++; $display("FAIL midwait_no_ack got %0d acks exp 0", acks);
        end
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(5'(a), 5'(a + 1));
            @(negedge clk);
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++; $display("FAIL midwait_regs addr %0d got %h exp 0", a, rd_data);
            end
        end
        step();
        do_dbg(1'b0, 5'd5, '0, 0, 5'd0, '0, ack_cyc, ack_cnt, ra, rb);
        n_checks++;
        if (ack_cyc != 2 || ra !== '0) begin
            n_fail++; $display("FAIL midwait_x5 got cyc %0d data %h exp cyc 2 data 0", ack_cyc, ra);
        end
    endtask

    task automatic test_random_reads();
        logic [DATA_W-1:0] ed;
        logic es;
        idle_inputs();
        for (int n = 0; n < 300; n++) begin
            wb_we = 1'($urandom_range(0, 1)); wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
            ex_we = 1'($urandom_range(0, 1)); ex_waddr = 5'($urandom_range(0, 7));
            ex_valid = 1'($urandom_range(0, 1)); ex_wdata = $urandom;
            mem_we = 1'($urandom_range(0, 1)); mem_waddr = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clk);
            for (int p = 0; p < NUM_RD; p++) begin
                exp_read(rd_addr[p*ADDR_W +: ADDR_W], ed, es);
                n_checks++;
                if (rd_stall[p] !== es) begin
                    n_fail++; $display("FAIL rand_stall n%0d port%0d got %b exp %b", n, p, rd_stall[p], es);
                end
                if (!es) begin
                    n_checks++;
                    if (rd_data[p*DATA_W +: DATA_W] !== ed) begin
                        n_fail++;
                        $display("FAIL rand_data n%0d port%0d got %h exp %h", n, p, rd_data[p*DATA_W +: DATA_W], ed);
                    end
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_random_dbg();
        int ack_cyc, ack_cnt;
        logic [DATA_W-1:0] ra, rb, exp_v;
        logic we;
        logic [ADDR_W-1:0] a;
        idle_inputs();
        for (int n = 0; n < 16; n++) begin
            we = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 7));
            ex_we = 1; ex_waddr = a; ex_valid = 1; ex_wdata = $urandom;
            mem_we = 1; mem_waddr = a; mem_wdata = $urandom;
            if (!we) exp_q.push_back(model_regs[a]);
            do_dbg(we, a, $urandom, 0, 5'd0, '0, ack_cyc, ack_cnt, ra, rb);
            n_checks++;
            if (ack_cyc != 2 || ack_cnt != 1) begin
                n_fail++; $display("FAIL rand_dbg_ack n%0d got cyc %0d cnt %0d exp cyc 2 cnt 1", n, ack_cyc, ack_cnt);
            end
            if (!we && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                n_checks++;
                if (ra !== exp_v) begin
                    n_fail++; $display("FAIL rand_dbg_rdata n%0d addr %0d got %h exp %h", n, a, ra, exp_v);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_fwd_priority();
        test_zero_reg();
        test_dbg_contended();
        test_dbg_read_bypass();
        test_random_reads();
        test_random_dbg();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
